// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hold/bubble control for load-use, EX redirects and memory waits, with stall/flush stats and a sticky memory-timeout flag
module hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       waddr_EX,
    input  logic             RegWrite_EX,
    input  logic             Mem2Reg_EX,
    input  logic             redirect_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ready_MEM,
    output logic             PC_EN,
    output logic             IF_ID_EN,
    output logic             IF_ID_flush,
    output logic             ID_EX_EN,
    output logic             ID_EX_flush,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             MEM_WB_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);
    localparam logic [0:0]  RUN   = 1'b0;
    localparam logic [0:0]  WAIT  = 1'b1;
    localparam logic [15:0] MAX_W = 16'(MAX_WAIT);

    logic        lu, mw, go;
    logic [0:0]  state;
    logic [15:0] wait_cnt;

    assign lu = Mem2Reg_EX & RegWrite_EX & (waddr_EX != 5'd0) &
                ((rs1_used_ID & (rs1_ID == waddr_EX)) | (rs2_used_ID & (rs2_ID == waddr_EX)));
    assign mw = mem_req_MEM & ~mem_ready_MEM;
    // A frozen pipeline defers any redirect; a redirect squashes the load-use victim.
    assign go = ~rst & ~mw;

    assign PC_EN        = go & (redirect_EX | ~lu);
    assign IF_ID_EN     = go & (redirect_EX | ~lu);
    assign IF_ID_flush  = go & redirect_EX;
    assign ID_EX_EN     = go;
    assign ID_EX_flush  = go & (redirect_EX | lu);
    assign EX_MEM_EN    = go;
    assign MEM_WB_EN    = ~rst;
    assign MEM_WB_flush = ~rst & mw;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((mw | (lu & ~redirect_EX)) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (redirect_EX && !mw && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (state == RUN) begin
            if (mw) begin
                state    <= WAIT;
                wait_cnt <= 16'd1;
            end
        end else if (mw) begin
            if (wait_cnt == MAX_W) mem_timeout <= 1'b1;
            else wait_cnt <= wait_cnt + 16'd1;
        end else begin
            state    <= RUN;
            wait_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with small counters and a short memory timeout
module tb_hazard_ctrl;
    localparam int CNT_W = 2;
    localparam int MAXW  = 4;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1_ID, rs2_ID, waddr_EX;
    logic rs1_used_ID, rs2_used_ID, RegWrite_EX, Mem2Reg_EX, redirect_EX, mem_req_MEM, mem_ready_MEM;
    logic PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN, MEM_WB_EN, MEM_WB_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic mem_timeout;

    hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .waddr_EX(waddr_EX),
        .RegWrite_EX(RegWrite_EX), .Mem2Reg_EX(Mem2Reg_EX), .redirect_EX(redirect_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ready_MEM(mem_ready_MEM), .PC_EN(PC_EN),
        .IF_ID_EN(IF_ID_EN), .IF_ID_flush(IF_ID_flush), .ID_EX_EN(ID_EX_EN),
        .ID_EX_flush(ID_EX_flush), .EX_MEM_EN(EX_MEM_EN), .MEM_WB_EN(MEM_WB_EN),
        .MEM_WB_flush(MEM_WB_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;
    logic [12:0] sb[$];
    logic [12:0] e, a;

    // Reference state: counters, timeout flag and wait tracking
    int m_stall, m_flush, m_wc;
    logic m_to, m_inwait;

    function automatic logic [12:0] dut_vec();
        return {PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN,
                MEM_WB_EN, MEM_WB_flush, stall_cnt, flush_cnt, mem_timeout};
    endfunction

    function automatic logic m_lu();
        return Mem2Reg_EX && RegWrite_EX && waddr_EX != 0 &&
               ((rs1_used_ID && rs1_ID == waddr_EX) || (rs2_used_ID && rs2_ID == waddr_EX));
    endfunction

    task automatic drive(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                         input logic u1, input logic u2, input logic [4:0] wa, input logic rw,
                         input logic m2r, input logic rd, input logic rq, input logic ry);
        logic [7:0] c;
        logic mw;
        rst = r; rs1_ID = s1; rs2_ID = s2; rs1_used_ID = u1; rs2_used_ID = u2;
        waddr_EX = wa; RegWrite_EX = rw; Mem2Reg_EX = m2r; redirect_EX = rd;
        mem_req_MEM = rq; mem_ready_MEM = ry;
        mw = rq && !ry;
        if (r) c = 8'b0000_0000;
        else if (mw) c = 8'b0000_0011;
        else if (rd) c = 8'b1111_1110;
        else if (m_lu()) c = 8'b0001_1110;
        else c = 8'b1101_0110;
        sb.push_back({c, 2'(m_stall), 2'(m_flush), m_to});
    endtask

    // Advances the reference model and the DUT across one posedge
    task automatic tick();
        logic mw;
        mw = mem_req_MEM && !mem_ready_MEM;
        if (rst) begin
            m_stall = 0; m_flush = 0; m_to = 0; m_wc = 0; m_inwait = 0;
        end else begin
            if ((mw || (m_lu() && !redirect_EX)) && m_stall < 3) m_stall++;
            if (redirect_EX && !mw && m_flush < 3) m_flush++;
            if (!m_inwait) begin
                if (mw) begin m_inwait = 1; m_wc = 1; end
            end else if (mw) begin
                if (m_wc == MAXW) m_to = 1;
                else m_wc++;
            end else begin
                m_inwait = 0; m_wc = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        drive(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        drive(1, 5, 5, 1, 1, 5, 1, 1, 1, 1, 0);
        @(negedge clk);
        e = sb.pop_front(); a = dut_vec(); vecs++;
        if (a !== e) begin miss++; $display("FAIL reset_ctrl got %b want %b", a, e); end
        tick();
        idle(0);
        @(negedge clk);
        e = sb.pop_front(); a = dut_vec(); vecs++;
        if (a !== e || stall_cnt !== 0 || flush_cnt !== 0 || mem_timeout !== 0) begin
            miss++; $display("FAIL reset_state got %b want %b", a, e);
        end
        tick();
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(0, 1, 5, 1, 1, 5, 1, 1, 0, 0, 1);
                1: drive(0, 1, 5, 1, 1, 0, 1, 1, 0, 0, 1);
                2: drive(0, 7, 2, 0, 1, 7, 1, 1, 0, 0, 1);
                3: drive(0, 7, 2, 1, 0, 7, 1, 1, 0, 0, 1);
                default: drive(0, 9, 9, 1, 1, 9, 0, 1, 0, 0, 1);
            endcase
            @(negedge clk);
            e = sb.pop_front(); a = dut_vec(); vecs++;
            if (a !== e) begin miss++; $display("FAIL load_use[%0d] got %b want %b", i, a, e); end
            if (i == 1) begin
                vecs++;
                if (stall_cnt !== 2'd1) begin miss++; $display("FAIL lu_stall_cnt got %0d want 1", stall_cnt); end
            end
            tick();
        end
    endtask

    task automatic test_redirect_lu();
        idle(1); @(negedge clk); void'(sb.pop_front()); tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(0, 3, 3, 1, 0, 3, 1, 1, 1, 0, 1);
            else idle(0);
            @(negedge clk);
            e = sb.pop_front(); a = dut_vec(); vecs++;
            if (a !== e) begin miss++; $display("FAIL redirect_lu[%0d] got %b want %b", i, a, e); end
            tick();
        end
        vecs++;
        if (flush_cnt !== 2'd1 || stall_cnt !== 2'd0) begin
            miss++; $display("FAIL redirect_lu_cnt got flush %0d stall %0d want 1 0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_mem_wait();
        idle(1); @(negedge clk); void'(sb.pop_front()); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, i >= 3);
            @(negedge clk);
            e = sb.pop_front(); a = dut_vec(); vecs++;
            if (a !== e) begin miss++; $display("FAIL mem_wait[%0d] got %b want %b", i, a, e); end
            if (i == 3) begin
                vecs++;
                if (stall_cnt !== 2'd3 || PC_EN !== 1'b1) begin
                    miss++; $display("FAIL mem_wait_done got stall %0d pc %b want 3 1", stall_cnt, PC_EN);
                end
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        idle(1); @(negedge clk); void'(sb.pop_front()); tick();
        for (int i = 0; i < 11; i++) begin
            if (i < 6) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            else idle(i == 9);
            @(negedge clk);
            e = sb.pop_front(); a = dut_vec(); vecs++;
            if (a !== e) begin miss++; $display("FAIL timeout[%0d] got %b want %b", i, a, e); end
            if (i == 8 || i == 10) begin
                vecs++;
                if (mem_timeout !== (i == 8)) begin
                    miss++; $display("FAIL timeout_sticky[%0d] got %b want %b", i, mem_timeout, i == 8);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect_wait();
        idle(1); @(negedge clk); void'(sb.pop_front()); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, i < 3, 1, i >= 2);
            @(negedge clk);
            e = sb.pop_front(); a = dut_vec(); vecs++;
            if (a !== e) begin miss++; $display("FAIL redirect_wait[%0d] got %b want %b", i, a, e); end
            tick();
        end
        vecs++;
        if (flush_cnt !== 2'd1) begin miss++; $display("FAIL redirect_wait_cnt got %0d want 1", flush_cnt); end
    endtask

    task automatic test_saturation();
        idle(1); @(negedge clk); void'(sb.pop_front()); tick();
        for (int i = 0; i < 10; i++) begin
            if (i < 5) drive(0, 6, 0, 1, 0, 6, 1, 1, 0, 0, 1);
            else drive(i == 7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            e = sb.pop_front(); a = dut_vec(); vecs++;
            if (a !== e) begin miss++; $display("FAIL saturation[%0d] got %b want %b", i, a, e); end
            if (i == 5) begin
                vecs++;
                if (stall_cnt !== 2'd3) begin miss++; $display("FAIL stall_sat got %0d want 3", stall_cnt); end
            end
            if (i == 8) begin
                vecs++;
                if (stall_cnt !== 0 || mem_timeout !== 0) begin
                    miss++; $display("FAIL rst_mid_wait got stall %0d to %b want 0 0", stall_cnt, mem_timeout);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 19) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 2) != 0);
            @(negedge clk);
            e = sb.pop_front(); a = dut_vec(); vecs++;
            if (a !== e) begin miss++; $display("FAIL random[%0d] got %b want %b", i, a, e); end
            tick();
        end
    endtask

    initial begin
        m_stall = 0; m_flush = 0; m_wc = 0; m_to = 0; m_inwait = 0;
        idle(1);
        void'(sb.pop_front());
        tick();
        test_reset();
        test_load_use();
        test_redirect_lu();
        test_mem_wait();
        test_timeout();
        test_redirect_wait();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller driving the EN/flush controls of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It detects load-use hazards, branch/jump redirects resolved in EX, and data-memory wait states, then emits hold/bubble commands. Two rules apply at every register: EN=0 holds it, and EN=1 with flush=1 loads a bubble (all control fields zero). It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.

## Interface
- CNT_W, 16: width of statistic counters.
- MAX_WAIT, 255: memory-wait cycles before mem_timeout sets (1..2^16-1).

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rs1_ID  in  5  source register 1 of instruction in ID.
- rs2_ID  in  5  source register 2 of instruction in ID.
- rs1_used_ID  in  1  ID instruction reads rs1.
- rs2_used_ID  in  1  ID instruction reads rs2.
- waddr_EX  in  5  destination of instruction in EX.
- RegWrite_EX  in  1  EX instruction writes register file.
- Mem2Reg_EX  in  1  EX instruction is a load.
- redirect_EX  in  1  taken branch/jump resolved in EX this cycle.
- mem_req_MEM  in  1  MEM instruction accesses data memory.
- mem_ready_MEM  in  1  data memory completes access this cycle.
- PC_EN  out  1  PC update enable.
- IF_ID_EN, IF_ID_flush  out  1 each  IF_ID controls.
- ID_EX_EN, ID_EX_flush  out  1 each  ID_EX controls.
- EX_MEM_EN  out  1  EX_MEM enable.
- MEM_WB_EN, MEM_WB_flush  out  1 each  MEM_WB controls.
- stall_cnt  out  CNT_W  load-use plus memory-wait stall cycles, saturating.
- flush_cnt  out  CNT_W  redirect events, saturating.
- mem_timeout  out  1  sticky: memory wait reached MAX_WAIT.

## Operation
- Hazard terms (combinational):
  - lu = Mem2Reg_EX & RegWrite_EX & (waddr_EX!=0) & ((rs1_used_ID & rs1_ID==waddr_EX) | (rs2_used_ID & rs2_ID==waddr_EX)).
  - mw = mem_req_MEM & ~mem_ready_MEM.
- Priority, highest first: mw > redirect_EX > lu > normal.
- mw (freeze):
  - PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN = 0.
  - MEM_WB_EN=1, MEM_WB_flush=1, so a bubble enters WB.
  - All other flushes = 0.
- redirect_EX:
  - PC_EN=1.
  - IF_ID_EN=1, IF_ID_flush=1.
  - ID_EX_EN=1, ID_EX_flush=1.
  - EX_MEM_EN=1, MEM_WB_EN=1, MEM_WB_flush=0.
  - A simultaneous lu is ignored: the ID instruction is squashed.
- lu:
  - PC_EN=0, IF_ID_EN=0.
  - ID_EX_EN=1, ID_EX_flush=1.
  - EX_MEM_EN=1, MEM_WB_EN=1, all other flushes 0.
- normal: all EN=1, all flushes 0.
- FSM (registered state):
  - RUN: on mw go to WAIT with wait_cnt=1; otherwise stay in RUN.
  - WAIT: while mw, wait_cnt increments (saturates at MAX_WAIT). When wait_cnt==MAX_WAIT and mw still holds, mem_timeout<=1. When ~mw, return to RUN with wait_cnt=0.
  - Outputs never depend on state, only on mw. State exists for timeout tracking only.
- Counters:
  - stall_cnt += 1 on every cycle with mw, or with lu while not redirecting.
  - flush_cnt += 1 on every cycle with redirect_EX & ~mw.
  - Both saturate at 2^CNT_W-1.
- mem_timeout clears only on rst.

## Timing
- Control outputs are combinational from inputs in the same cycle, with zero latency. The pipeline registers act on the next clk edge.
- Registered state/counters update on posedge clk. stall_cnt/flush_cnt reflect an event one cycle after it occurs.
- While rst=1, all EN and flush outputs = 0 (the pipeline registers are also in reset).
- Reset values on the edge with rst=1: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, mem_timeout=0.
- rst asserted during WAIT: back in RUN next cycle, no timeout set that cycle.
- Load-use stall lasts exactly one cycle per hazard. Next cycle the load is in MEM, so lu is 0.
- redirect_EX held during mw is deferred: EX is frozen, so the redirect is honoured on the first non-mw cycle and counted once then.
- waddr_EX=0 never produces lu.

## Test plan
- Load-use: Mem2Reg_EX=1, RegWrite_EX=1, waddr_EX=5, rs2_ID=5, rs2_used_ID=1 -> PC_EN=0, IF_ID_EN=0, ID_EX_EN=1, ID_EX_flush=1; stall_cnt 0->1 next cycle. Same with waddr_EX=0 -> all EN=1, no flush.
- Redirect plus load-use together: redirect_EX=1 with lu true -> IF_ID_flush=1, ID_EX_flush=1, PC_EN=1; flush_cnt +1, stall_cnt unchanged.
- Memory wait: mem_req_MEM=1, mem_ready_MEM=0 for 3 cycles, then 1 -> 3 cycles of PC/IF_ID/ID_EX/EX_MEM EN=0 with MEM_WB_flush=1; stall_cnt=3; 4th cycle all EN=1.
- Timeout: MAX_WAIT=4, mw held 6 cycles -> mem_timeout=1 after the 4th wait edge; it stays 1 after mw drops until rst.
- Redirect during wait: redirect_EX=1 and mw for 2 cycles, then mw=0 -> flush outputs 0 during the wait; one flush cycle after, with flush_cnt +1 total.
- Saturation/reset: CNT_W=2, five lu events -> stall_cnt=3. Assert rst mid-WAIT -> all outputs 0, counters 0.
